// File: rtl/udp_tx_channel_arbiter.sv
// Packet-level round-robin merge of NUM_CHANNELS user streams into the UDP TX path, with lookup and
// length side channels. Define UDP_TX_ARB_STATS_EN to add packet and oversize counters.
module udp_tx_channel_arbiter #(
  parameter int unsigned DATA_WIDTH        = 512,
  parameter int unsigned NUM_CHANNELS      = 4,
  parameter int unsigned CONN_ID_WIDTH     = 18,
  parameter int unsigned LEN_WIDTH         = 16,
  parameter int unsigned MAX_PAYLOAD_BYTES = 1472
) (
  input  logic                                   tx_axis_aclk,
  input  logic                                   tx_axis_areset,
  input  logic [NUM_CHANNELS-1:0]                s_axis_tvalid,
  output logic [NUM_CHANNELS-1:0]                s_axis_tready,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic [NUM_CHANNELS*DATA_WIDTH/8-1:0]   s_axis_tkeep,
  input  logic [NUM_CHANNELS-1:0]                s_axis_tlast,
  input  logic [NUM_CHANNELS*CONN_ID_WIDTH-1:0]  s_axis_connection_id,
  output logic                                   m_axis_tvalid,
  input  logic                                   m_axis_tready,
  output logic [DATA_WIDTH-1:0]                  m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]                m_axis_tkeep,
  output logic                                   m_axis_tlast,
  output logic [$clog2(NUM_CHANNELS)-1:0]        m_axis_tid,
  output logic                                   lookup_valid,
  input  logic                                   lookup_ready,
  output logic [CONN_ID_WIDTH-1:0]               lookup_connectionId,
  output logic                                   len_valid,
  input  logic                                   len_ready,
  output logic [LEN_WIDTH-1:0]                   len_data,
  output logic                                   len_oversize
`ifdef UDP_TX_ARB_STATS_EN
  ,
  output logic [NUM_CHANNELS*32-1:0]             stat_pkt_count,
  output logic [31:0]                            stat_oversize_count
`endif
);

  localparam int unsigned KeepWidth = DATA_WIDTH / 8;
  localparam int unsigned IdWidth   = $clog2(NUM_CHANNELS);
  localparam logic [LEN_WIDTH:0] BeatBytes = (LEN_WIDTH + 1)'(KeepWidth);
  localparam logic [LEN_WIDTH:0] MaxBytes  = (LEN_WIDTH + 1)'(MAX_PAYLOAD_BYTES);

  typedef enum logic {StIdle, StLocked} state_e;

  state_e               state_q;
  logic [IdWidth-1:0]   grant_q;
  logic [IdWidth-1:0]   last_grant_q;
  logic                 first_beat_q;
  logic [LEN_WIDTH:0]   acc_q;
  logic                 oversize_q;

  logic                     sel_valid;
  logic                     sel_last;
  logic [DATA_WIDTH-1:0]    sel_data;
  logic [KeepWidth-1:0]     sel_keep;
  logic [CONN_ID_WIDTH-1:0] sel_id;
  logic                     locked;
  logic                     lookup_ok;
  logic                     len_ok;
  logic                     beat_ok;
  logic                     fire;
  logic [LEN_WIDTH:0]       keep_bytes;
  logic [LEN_WIDTH:0]       acc_next;
  logic                     over_next;
  logic                     arb_found;
  logic [IdWidth-1:0]       arb_pick;
  int                       arb_idx;

  assign sel_valid = s_axis_tvalid[grant_q];
  assign sel_last  = s_axis_tlast[grant_q];
  assign sel_data  = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
  assign sel_keep  = s_axis_tkeep[grant_q*KeepWidth +: KeepWidth];
  assign sel_id    = s_axis_connection_id[grant_q*CONN_ID_WIDTH +: CONN_ID_WIDTH];

  // Data, lookup and length are gated by each other so all three transfer in the same cycle.
  assign locked    = (state_q == StLocked);
  assign lookup_ok = !first_beat_q || lookup_ready;
  assign len_ok    = !sel_last || len_ready;
  assign beat_ok   = locked && lookup_ok && len_ok;
  assign fire      = m_axis_tvalid && m_axis_tready;

  always_comb begin
    s_axis_tready          = '0;
    s_axis_tready[grant_q] = beat_ok && m_axis_tready;
  end

  assign m_axis_tvalid = beat_ok && sel_valid;
  assign m_axis_tdata  = sel_data;
  assign m_axis_tkeep  = sel_keep;
  assign m_axis_tlast  = sel_last;
  assign m_axis_tid    = grant_q;

  assign lookup_valid        = locked && first_beat_q && sel_valid && m_axis_tready && len_ok;
  assign lookup_connectionId = sel_id;
  assign len_valid           = locked && sel_valid && sel_last && m_axis_tready && lookup_ok;

  assign keep_bytes   = (LEN_WIDTH + 1)'($countones(sel_keep));
  assign acc_next     = acc_q + (sel_last ? keep_bytes : BeatBytes);
  assign over_next    = oversize_q || (acc_next > MaxBytes) || acc_next[LEN_WIDTH];
  assign len_data     = acc_next[LEN_WIDTH-1:0];
  assign len_oversize = over_next;

  // First requester strictly after the previous winner, modulo NUM_CHANNELS.
  always_comb begin
    arb_found = 1'b0;
    arb_pick  = '0;
    arb_idx   = 0;
    for (int i = 1; i <= int'(NUM_CHANNELS); i++) begin
      arb_idx = (int'(last_grant_q) + i) % int'(NUM_CHANNELS);
      if (!arb_found && s_axis_tvalid[arb_idx[IdWidth-1:0]]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx[IdWidth-1:0];
      end
    end
  end

  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= IdWidth'(NUM_CHANNELS - 1);
      first_beat_q <= 1'b0;
      acc_q        <= '0;
      oversize_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (arb_found) begin
            grant_q      <= arb_pick;
            state_q      <= StLocked;
            first_beat_q <= 1'b1;
            acc_q        <= '0;
            oversize_q   <= 1'b0;
          end
        end
        StLocked: begin
          if (fire) begin
            first_beat_q <= 1'b0;
            acc_q        <= acc_next;
            oversize_q   <= over_next;
            if (sel_last) begin
              last_grant_q <= grant_q;
              state_q      <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef UDP_TX_ARB_STATS_EN
  always_ff @(posedge tx_axis_aclk) begin
    if (tx_axis_areset) begin
      stat_pkt_count      <= '0;
      stat_oversize_count <= '0;
    end else begin
      if (fire && sel_last) begin
        stat_pkt_count[grant_q*32 +: 32] <= stat_pkt_count[grant_q*32 +: 32] + 32'd1;
      end
      if (len_valid && len_ready && len_oversize) begin
        stat_oversize_count <= stat_oversize_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_udp_tx_channel_arbiter.sv
// Randomized bench for udp_tx_channel_arbiter: packet-descriptor sources, a cycle reference model of
// the arbitration/handshake rules and packet-level expectations for grant order and length.
module tb_udp_tx_channel_arbiter;

  localparam int NC   = 4;
  localparam int DW   = 512;
  localparam int KW   = DW / 8;
  localparam int CW   = 18;
  localparam int LW   = 16;
  localparam int MAXP = 1472;
  localparam int TW   = $clog2(NC);

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NC-1:0]    s_tvalid, s_tready, s_tlast;
  logic [NC*DW-1:0] s_tdata;
  logic [NC*KW-1:0] s_tkeep;
  logic [NC*CW-1:0] s_cid;
  logic             m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [TW-1:0]    m_tid;
  logic             lookup_valid, lookup_ready;
  logic [CW-1:0]    lookup_id;
  logic             len_valid, len_ready;
  logic [LW-1:0]    len_data;
  logic             len_oversize;
`ifdef UDP_TX_ARB_STATS_EN
  logic [NC*32-1:0] stat_pkt_count;
  logic [31:0]      stat_oversize_count;
`endif

  udp_tx_channel_arbiter #(
    .DATA_WIDTH(DW), .NUM_CHANNELS(NC), .CONN_ID_WIDTH(CW), .LEN_WIDTH(LW),
    .MAX_PAYLOAD_BYTES(MAXP)
  ) dut (
    .tx_axis_aclk(clk), .tx_axis_areset(rst),
    .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready), .s_axis_tdata(s_tdata),
    .s_axis_tkeep(s_tkeep), .s_axis_tlast(s_tlast), .s_axis_connection_id(s_cid),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_connectionId(lookup_id),
    .len_valid(len_valid), .len_ready(len_ready), .len_data(len_data),
    .len_oversize(len_oversize)
`ifdef UDP_TX_ARB_STATS_EN
    , .stat_pkt_count(stat_pkt_count), .stat_oversize_count(stat_oversize_count)
`endif
  );

  always #5 clk = ~clk;

  // Per-channel packet descriptors: beat count, bytes in last beat, connection id.
  int          q_beats[NC][$];
  int          q_lastb[NC][$];
  logic [CW-1:0] q_cid[NC][$];
  int          cur_beat[NC];
  bit          src_valid[NC];
  logic [DW-1:0] cur_data[NC];
  int src_prob, mrdy_prob, lrdy_prob, nrdy_prob;

  // Reference model of the arbiter.
  bit mdl_locked, mdl_first;
  int mdl_owner, mdl_prev;

  int gq[$];
  int obs_len[$];
  bit obs_ovs[$];
  int beats_out;
  int done_pkts[NC];
  int ovs_cnt;
  int checks = 0;
  int errors = 0;

  function automatic logic [KW-1:0] keep_mask(int nbytes);
    logic [KW-1:0] k;
    for (int b = 0; b < KW; b++) k[b] = (b < nbytes);
    return k;
  endfunction

  function automatic bit pending();
    for (int c = 0; c < NC; c++) if (q_beats[c].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic add_pkt(input int ch, input int beats, input int lastb, input logic [CW-1:0] cid);
    q_beats[ch].push_back(beats);
    q_lastb[ch].push_back(lastb);
    q_cid[ch].push_back(cid);
  endtask

  task automatic set_probs(input int s, input int m, input int l, input int n);
    src_prob = s; mrdy_prob = m; lrdy_prob = l; nrdy_prob = n;
  endtask

  task automatic flush_sources();
    for (int c = 0; c < NC; c++) begin
      q_beats[c].delete(); q_lastb[c].delete(); q_cid[c].delete();
      cur_beat[c] = 0; src_valid[c] = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < NC; c++) begin
      if (!src_valid[c] && q_beats[c].size() > 0 && $urandom_range(0, 99) < src_prob) begin
        src_valid[c] = 1'b1;
        for (int w = 0; w < DW / 32; w++) cur_data[c][w*32 +: 32] = $urandom;
      end
      s_tvalid[c] = src_valid[c];
      s_tdata[c*DW +: DW] = cur_data[c];
      if (q_beats[c].size() > 0) begin
        s_tlast[c] = (cur_beat[c] == q_beats[c][0] - 1);
        s_tkeep[c*KW +: KW] = s_tlast[c] ? keep_mask(q_lastb[c][0]) : {KW{1'b1}};
        s_cid[c*CW +: CW] = q_cid[c][0];
      end else begin
        s_tlast[c] = 1'b0;
        s_tkeep[c*KW +: KW] = '0;
        s_cid[c*CW +: CW] = '0;
      end
    end
    m_tready     = ($urandom_range(0, 99) < mrdy_prob);
    lookup_ready = ($urandom_range(0, 99) < lrdy_prob);
    len_ready    = ($urandom_range(0, 99) < nrdy_prob);
  endtask

  // One clock cycle: drive, sample before the next edge, compare, advance sources and model.
  task automatic step();
    int o;
    logic sv, sl, lk_ok, ln_ok, e_mv, e_lv, e_nv;
    logic [NC-1:0] e_rdy;
    int total;
    bit e_ovs;
    drive_inputs();
    #3;
    o = mdl_owner;
    sv = s_tvalid[o];
    sl = s_tlast[o];
    lk_ok = !mdl_first || lookup_ready;
    ln_ok = !sl || len_ready;
    e_mv = mdl_locked && sv && lk_ok && ln_ok;
    e_rdy = '0;
    if (mdl_locked && m_tready && lk_ok && ln_ok) e_rdy[o] = 1'b1;
    e_lv = mdl_locked && mdl_first && sv && m_tready && ln_ok;
    e_nv = mdl_locked && sv && sl && m_tready && lk_ok;

    checks++;
    if ({m_tvalid, s_tready, lookup_valid, len_valid} !== {e_mv, e_rdy, e_lv, e_nv}) begin
      errors++;
      $display("FAIL handshake t=%0t: got mvalid=%b tready=%b lookup=%b len=%b, want %b %b %b %b",
               $time, m_tvalid, s_tready, lookup_valid, len_valid, e_mv, e_rdy, e_lv, e_nv);
    end
    if (e_mv) begin
      checks++;
      if ({m_tdata, m_tkeep, m_tlast, m_tid} !== {s_tdata[o*DW +: DW], s_tkeep[o*KW +: KW], sl, TW'(o)})
      begin
        errors++;
        $display("FAIL beat t=%0t: got tid=%0d last=%b keep=%h d=%h, want tid=%0d last=%b keep=%h d=%h",
                 $time, m_tid, m_tlast, m_tkeep, m_tdata[63:0], o, sl, s_tkeep[o*KW +: KW],
                 s_tdata[o*DW +: 64]);
      end
    end
    if (e_lv) begin
      checks++;
      if (lookup_id !== q_cid[o][0]) begin
        errors++;
        $display("FAIL lookup_id t=%0t: got %h want %h", $time, lookup_id, q_cid[o][0]);
      end
    end
    if (e_nv) begin
      total = (q_beats[o][0] - 1) * KW + q_lastb[o][0];
      e_ovs = (total > MAXP) || (total > (1 << LW) - 1);
      checks++;
      if ({len_data, len_oversize} !== {LW'(total), e_ovs}) begin
        errors++;
        $display("FAIL len t=%0t: got len=%0d ovs=%b want len=%0d ovs=%b",
                 $time, len_data, len_oversize, total, e_ovs);
      end
      if (len_ready && e_ovs) ovs_cnt++;
    end
    if (len_valid && len_ready) begin
      obs_len.push_back(int'(len_data));
      obs_ovs.push_back(len_oversize);
    end
    if (m_tvalid && m_tready) beats_out++;

    for (int c = 0; c < NC; c++) begin
      if (s_tvalid[c] && s_tready[c]) begin
        src_valid[c] = 1'b0;
        if (s_tlast[c]) begin
          void'(q_beats[c].pop_front()); void'(q_lastb[c].pop_front()); void'(q_cid[c].pop_front());
          cur_beat[c] = 0;
          done_pkts[c]++;
        end else begin
          cur_beat[c]++;
        end
      end
    end

    if (mdl_locked) begin
      if (e_mv && m_tready) begin
        mdl_first = 1'b0;
        if (sl) begin
          mdl_locked = 1'b0;
          mdl_prev = o;
        end
      end
    end else begin
      for (int i = 1; i <= NC; i++) begin
        if (!mdl_locked && s_tvalid[(mdl_prev + i) % NC]) begin
          mdl_owner = (mdl_prev + i) % NC;
          mdl_locked = 1'b1;
          mdl_first = 1'b1;
          gq.push_back(mdl_owner);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_drained(input int max_cycles, output int used);
    used = 0;
    while ((pending() || mdl_locked) && used < max_cycles) begin
      step();
      used++;
    end
    checks++;
    if (pending() || mdl_locked) begin
      errors++;
      $display("FAIL drain_timeout: got packets still pending after %0d cycles, want none", used);
    end
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    drive_inputs();
    @(posedge clk);
    #1;
    drive_inputs();
    #3;
    checks++;
    if ({m_tvalid, s_tready, lookup_valid, len_valid, m_tid} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got mvalid=%b tready=%b lookup=%b len=%b tid=%0d, want all 0",
               m_tvalid, s_tready, lookup_valid, len_valid, m_tid);
    end
`ifdef UDP_TX_ARB_STATS_EN
    checks++;
    if ({stat_pkt_count, stat_oversize_count} !== '0) begin
      errors++;
      $display("FAIL reset_stats: got pkt=%h ovs=%0d want 0", stat_pkt_count, stat_oversize_count);
    end
`endif
    flush_sources();
    @(posedge clk);
    #1;
    rst = 1'b0;
    mdl_locked = 1'b0; mdl_first = 1'b0; mdl_owner = 0; mdl_prev = NC - 1;
    for (int c = 0; c < NC; c++) done_pkts[c] = 0;
    ovs_cnt = 0;
  endtask

  task automatic clear_logs();
    gq.delete(); obs_len.delete(); obs_ovs.delete();
  endtask

  task automatic test_reset();
    set_probs(100, 100, 100, 100);
    add_pkt(2, 3, 20, 18'h00123);
    apply_reset();
  endtask

  task automatic test_single_ch1();
    int used;
    clear_logs();
    set_probs(100, 100, 100, 100);
    add_pkt(1, 3, 40, 18'h2A5A5);
    run_until_drained(50, used);
    checks++;
    if (gq.size() != 1 || gq[0] != 1 || used != 4) begin
      errors++;
      $display("FAIL single_ch1_grant: got grants=%0d cycles=%0d, want one grant to ch1 in 4 cycles",
               gq.size(), used);
    end
    checks++;
    if (obs_len.size() != 1 || obs_len[0] != 168 || obs_ovs[0] != 1'b0) begin
      errors++;
      $display("FAIL single_ch1_len: got %0d records, want one record len=168 ovs=0", obs_len.size());
    end
  endtask

  task automatic test_round_robin();
    int used;
    int exp_order[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    bit ok;
    apply_reset();
    clear_logs();
    set_probs(100, 100, 100, 100);
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < NC; c++) add_pkt(c, 1, (c == 3 && r == 0) ? 0 : 8 * (c + 1), CW'(c * 16 + r));
    run_until_drained(100, used);
    ok = (gq.size() == 8);
    for (int i = 0; i < 8 && ok; i++) ok = (gq[i] == exp_order[i]);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rr_order: got %p want 0,1,2,3,0,1,2,3", gq);
    end
    checks++;
    if (used != 16) begin
      errors++;
      $display("FAIL rr_spacing: got %0d cycles want 16", used);
    end
  endtask

  task automatic test_holdoff();
    int used, n;
    clear_logs();
    set_probs(50, 100, 100, 100);
    add_pkt(2, 4, 33, 18'h3C3C3);
    n = 0;
    while (!(mdl_locked && mdl_owner == 2) && n < 40) begin
      step();
      n++;
    end
    add_pkt(0, 1, 12, 18'h00A00);
    add_pkt(3, 2, 64, 18'h00B03);
    run_until_drained(200, used);
    checks++;
    if (gq.size() != 3 || gq[0] != 2 || gq[1] != 3 || gq[2] != 0) begin
      errors++;
      $display("FAIL holdoff_order: got %p want 2,3,0", gq);
    end
  endtask

  task automatic test_lookup_stall();
    int used, n, b0;
    clear_logs();
    set_probs(100, 100, 0, 100);
    add_pkt(1, 2, 64, 18'h15151);
    n = 0;
    while (!mdl_locked && n < 20) begin
      step();
      n++;
    end
    b0 = beats_out;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (beats_out != b0 || obs_len.size() != 0) begin
      errors++;
      $display("FAIL lookup_stall: got %0d beats %0d len records, want 0 0", beats_out - b0,
               obs_len.size());
    end
    lrdy_prob = 100;
    step();
    checks++;
    if (beats_out != b0 + 1) begin
      errors++;
      $display("FAIL lookup_release: got %0d beats want 1", beats_out - b0);
    end
    run_until_drained(50, used);
    checks++;
    if (obs_len.size() != 1 || obs_len[0] != 128) begin
      errors++;
      $display("FAIL lookup_stall_len: got %0d records want one len=128", obs_len.size());
    end
  endtask

  task automatic test_oversize();
    int used;
    clear_logs();
    set_probs(100, 100, 100, 100);
    add_pkt(0, 25, 64, 18'h0F00D);
    run_until_drained(100, used);
    checks++;
    if (obs_len.size() != 1 || obs_len[0] != 1600 || obs_ovs[0] != 1'b1) begin
      errors++;
      $display("FAIL oversize: got %0d records, want one len=1600 ovs=1", obs_len.size());
    end
`ifdef UDP_TX_ARB_STATS_EN
    checks++;
    if (stat_oversize_count !== 32'd1) begin
      errors++;
      $display("FAIL stat_oversize: got %0d want 1", stat_oversize_count);
    end
`endif
  endtask

  task automatic test_reset_midpacket();
    int used, n;
    clear_logs();
    set_probs(100, 100, 100, 100);
    add_pkt(1, 4, 64, 18'h11111);
    n = 0;
    while (cur_beat[1] < 1 && n < 20) begin
      step();
      n++;
    end
    apply_reset();
    clear_logs();
    add_pkt(3, 1, 30, 18'h33333);
    add_pkt(0, 2, 10, 18'h00000);
    run_until_drained(50, used);
    checks++;
    if (gq.size() != 2 || gq[0] != 0 || gq[1] != 3) begin
      errors++;
      $display("FAIL reset_priority: got %p want 0,3", gq);
    end
    checks++;
    if (obs_len.size() != 2 || obs_len[0] != 74 || obs_len[1] != 30) begin
      errors++;
      $display("FAIL reset_acc: got %p want 74,30", obs_len);
    end
  endtask

  task automatic test_random();
    int used, beats;
    clear_logs();
    set_probs(70, 75, 70, 70);
    for (int p = 0; p < 40; p++) begin
      beats = ($urandom_range(0, 19) == 0) ? $urandom_range(23, 26) : $urandom_range(1, 5);
      add_pkt($urandom_range(0, NC - 1), beats, $urandom_range(0, KW), CW'($urandom));
    end
    run_until_drained(20000, used);
`ifdef UDP_TX_ARB_STATS_EN
    for (int c = 0; c < NC; c++) begin
      checks++;
      if (stat_pkt_count[c*32 +: 32] !== 32'(done_pkts[c])) begin
        errors++;
        $display("FAIL stat_pkt ch%0d: got %0d want %0d", c, stat_pkt_count[c*32 +: 32], done_pkts[c]);
      end
    end
    checks++;
    if (stat_oversize_count !== 32'(ovs_cnt)) begin
      errors++;
      $display("FAIL stat_ovs_random: got %0d want %0d", stat_oversize_count, ovs_cnt);
    end
`endif
  endtask

  initial begin
    s_tvalid = '0; s_tlast = '0; s_tdata = '0; s_tkeep = '0; s_cid = '0;
    m_tready = 1'b0; lookup_ready = 1'b0; len_ready = 1'b0;
    beats_out = 0; ovs_cnt = 0;
    for (int c = 0; c < NC; c++) begin
      cur_beat[c] = 0; src_valid[c] = 1'b0; cur_data[c] = '0; done_pkts[c] = 0;
    end
    mdl_locked = 1'b0; mdl_first = 1'b0; mdl_owner = 0; mdl_prev = NC - 1;
    @(posedge clk);
    #1;
    test_reset();
    test_single_ch1();
    test_round_robin();
    test_holdoff();
    test_lookup_stall();
    test_oversize();
    test_reset_midpacket();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got simulation still running, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/udp_tx_channel_arbiter.md
Name: udp_tx_channel_arbiter

Overview:
Multi-channel front end for the UDP TX path. It accepts NUM_CHANNELS independent user AXI-Stream packet inputs, each with its own connection ID, and merges them into one stream using packet-level round-robin arbitration. Per packet it emits one reverse-lookup request on the first beat and one payload-length record on the last beat. It sits between user logic and the TX packet/metadata FIFOs feeding header prepend, and replaces the single-channel input stage.

Parameters:
- DATA_WIDTH, 512, stream width in bits; multiple of 8.
- NUM_CHANNELS, 4, number of user input channels; 2..16.
- CONN_ID_WIDTH, 18, connection ID width.
- LEN_WIDTH, 16, payload length field width.
- MAX_PAYLOAD_BYTES, 1472, any length above this sets the oversize flag.

Ports:
- tx_axis_aclk  in  1  clock.
- tx_axis_areset  in  1  synchronous reset, active-high.
- s_axis_tvalid  in  NUM_CHANNELS  per-channel valid.
- s_axis_tready  out  NUM_CHANNELS  per-channel ready.
- s_axis_tdata  in  NUM_CHANNELS*DATA_WIDTH  packed per-channel data; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  NUM_CHANNELS*DATA_WIDTH/8  packed per-channel keep.
- s_axis_tlast  in  NUM_CHANNELS  per-channel last.
- s_axis_connection_id  in  NUM_CHANNELS*CONN_ID_WIDTH  per-channel connection ID; sampled on the first beat only.
- m_axis_tvalid, m_axis_tready  out/in  1 each  merged output handshake.
- m_axis_tdata  out  DATA_WIDTH  merged output data.
- m_axis_tkeep  out  DATA_WIDTH/8  merged output keep.
- m_axis_tlast  out  1  merged output last.
- m_axis_tid  out  $clog2(NUM_CHANNELS)  index of the granted channel.
- lookup_valid  out  1  reverse-lookup request valid.
- lookup_ready  in  1  reverse-lookup request ready.
- lookup_connectionId  out  CONN_ID_WIDTH  connection ID of the granted channel.
- len_valid  out  1  length record valid.
- len_ready  in  1  length record ready.
- len_data  out  LEN_WIDTH  payload byte count.
- len_oversize  out  1  payload exceeded MAX_PAYLOAD_BYTES or overflowed LEN_WIDTH.

Behaviour:

State machine, two states:
- IDLE
  - All s_axis_tready = 0; m_axis_tvalid = 0.
  - If any s_axis_tvalid is high, register grant = first requesting channel strictly after last_grant, scanning modulo NUM_CHANNELS.
  - Then go to LOCKED and set first_beat = 1.
  - Exactly one bubble cycle per packet.
- LOCKED
  - Output is a combinational mux of the granted channel: m_axis_tvalid, tdata, tkeep, tlast, and tid = grant.
  - Beat fire condition: fire = s_tvalid[g] & m_axis_tready & (!first_beat | lookup_ready) & (!s_tlast[g] | len_ready).
  - s_axis_tready[g] = m_axis_tready & lookup gating & len gating. Non-granted channels see tready = 0.
  - m_axis_tvalid is gated by the same lookup and length conditions, so no beat leaves without its metadata being accepted.
- lookup_valid = first_beat & s_tvalid[g] & m_axis_tready & (!s_tlast[g] | len_ready). lookup_connectionId = s_axis_connection_id[g].
- len_valid = s_tvalid[g] & s_tlast[g] & m_axis_tready & (!first_beat | lookup_ready).
- Result: lookup, length and data beat all fire in the same cycle or none fire. A single-beat packet fires all three together.

Length computation:
- acc is LEN_WIDTH+1 bits, cleared on packet start.
- Each non-last fired beat adds DATA_WIDTH/8; the last beat adds $countones(tkeep).
- len_data = acc[LEN_WIDTH-1:0], presented combinationally on the last beat.
- len_oversize = 1 if the total exceeds MAX_PAYLOAD_BYTES or bit LEN_WIDTH is set (sticky within the packet).
- tkeep is assumed contiguous from LSB; a non-last beat is always full.

Transitions and state updates:
- When the last beat fires: last_grant <= grant, next state IDLE.
- first_beat clears on the first fired beat.
- Grant never changes mid-packet, regardless of tvalid deassertion on the granted channel.

Reset:
- Synchronous, active-high. Any in-flight packet is abandoned.
- Reset values: state = IDLE, last_grant = NUM_CHANNELS-1 (so channel 0 wins first), grant = 0, acc = 0, first_beat = 0.
- Therefore all tready, m_axis_tvalid, lookup_valid and len_valid are 0; m_axis_tid = 0.

Boundaries:
- Zero-byte last beat (tkeep = 0) is legal; it adds 0.
- If all channels are idle, the block stays in IDLE.

Optional Feature:
UDP_TX_ARB_STATS_EN.
- Defined: adds output stat_pkt_count (NUM_CHANNELS*32) and stat_oversize_count (32).
  - Per-channel packet counters increment on that channel's last fired beat.
  - The oversize counter increments on each len_valid & len_ready with len_oversize = 1.
  - All counters wrap at 2^32 and are cleared by reset.
- Undefined: these ports and registers do not exist.

Test Plan:
- Ch1 only, 3 beats (full, full, last tkeep = 0x0000_00FF_...FF = 40 bytes), DATA_WIDTH = 512 -> m_axis_tid = 1 on all beats, lookup fires on beat 1 with ch1 ID, len_data = 168, len_oversize = 0, one bubble cycle before beat 1.
- All 4 channels request continuous 1-beat packets -> grant order 0,1,2,3,0,1, each packet separated by one IDLE cycle.
- Ch2 granted mid-packet; ch0 asserts tvalid -> ch0 held off until ch2's tlast fires, then ch3 (if requesting) precedes ch0.
- lookup_ready = 0 for 5 cycles on the first beat -> no data beat, no len_valid, s_axis_tready[g] = 0; everything fires together when ready rises.
- 24 full beats of 64 bytes plus a last beat of 64 bytes (1600 B) -> len_data = 1600, len_oversize = 1; with macro defined, stat_oversize_count = 1.
- Reset asserted on beat 2 of a 4-beat packet -> next cycle all valids = 0; after release, channel 0 has priority and acc restarts at 0.
